// File: rtl/rgb_byte_assembler_pkg.sv
// rgb_byte_assembler_pkg: shared FSM encoding, pixel width and counter-width helper
package rgb_byte_assembler_pkg;

    localparam int PIXEL_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_R    = 2'd1,
        S_G    = 2'd2,
        S_B    = 2'd3
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rgb_byte_assembler_if.sv
// rgb_byte_assembler_if: camera byte stream in, assembled RGB pixel stream out
interface rgb_byte_assembler_if;
    import rgb_byte_assembler_pkg::*;

    logic [PIXEL_W-1:0] in_byte;
    logic               byte_valid_in;
    logic               sof_in;
    logic [PIXEL_W-1:0] out_red_pixel;
    logic [PIXEL_W-1:0] out_green_pixel;
    logic [PIXEL_W-1:0] out_blue_pixel;
    logic               RGB_valid_out;
    logic               sof_out;
    logic               eol_out;
    logic               frame_done;
    logic               frame_err;

    modport master (
        output in_byte, byte_valid_in, sof_in,
        input  out_red_pixel, out_green_pixel, out_blue_pixel,
        input  RGB_valid_out, sof_out, eol_out, frame_done, frame_err
    );

    modport slave (
        input  in_byte, byte_valid_in, sof_in,
        output out_red_pixel, out_green_pixel, out_blue_pixel,
        output RGB_valid_out, sof_out, eol_out, frame_done, frame_err
    );

endinterface

// File: rtl/pixel_position_counter.sv
// pixel_position_counter: col/row position of the next pixel to be emitted
module pixel_position_counter
    import rgb_byte_assembler_pkg::*;
#(
    parameter  int IMG_WIDTH  = 640,
    parameter  int IMG_HEIGHT = 480,
    localparam int CW         = cnt_w(IMG_WIDTH),
    localparam int RW         = cnt_w(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic          clear,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          eol,
    output logic          last
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    assign col  = col_q;
    assign row  = row_q;
    assign eol  = col_q == CW'(IMG_WIDTH - 1);
    assign last = eol && (row_q == RW'(IMG_HEIGHT - 1));

    // clear wins over step; the last pixel of a frame wraps both counters
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (step) begin
            col_d = eol ? '0 : col_q + CW'(1);
            row_d = last ? '0 : (eol ? row_q + RW'(1) : row_q);
        end
    end

    // position registers
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/rgb_byte_assembler.sv
// rgb_byte_assembler: packs an R,G,B byte stream into pixels with frame/line flags
module rgb_byte_assembler
    import rgb_byte_assembler_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 RGB_enable,
    rgb_byte_assembler_if.slave bus
);

    localparam int CW = cnt_w(IMG_WIDTH);
    localparam int RW = cnt_w(IMG_HEIGHT);

    state_t             state_q, state_d;
    logic [PIXEL_W-1:0] r_q, r_d, g_q, g_d;
    logic [PIXEL_W-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
    logic               valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
    logic               done_q, done_d, err_q, err_d;
    logic               step, clear, eol, last, at_origin;
    logic [CW-1:0]      col;
    logic [RW-1:0]      row;

    pixel_position_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT)
    ) u_pos (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .clear(clear),
        .col  (col),
        .row  (row),
        .eol  (eol),
        .last (last)
    );

    assign at_origin = (col == '0) && (row == '0);

    // byte-phase FSM; a valid sof byte always restarts the frame as its red byte
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        g_d     = g_q;
        red_d   = red_q;
        grn_d   = grn_q;
        blu_d   = blu_q;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        step    = 1'b0;
        clear   = 1'b0;
        if (!RGB_enable) begin
            state_d = S_IDLE;
            r_d     = '0;
            g_d     = '0;
            clear   = 1'b1;
        end else if (bus.byte_valid_in && bus.sof_in) begin
            err_d   = (state_q != S_IDLE) && !(state_q == S_R && at_origin);
            r_d     = bus.in_byte;
            g_d     = '0;
            clear   = 1'b1;
            state_d = S_G;
        end else if (bus.byte_valid_in) begin
            if (state_q == S_R) begin
                r_d     = bus.in_byte;
                state_d = S_G;
            end else if (state_q == S_G) begin
                g_d     = bus.in_byte;
                state_d = S_B;
            end else if (state_q == S_B) begin
                red_d   = r_q;
                grn_d   = g_q;
                blu_d   = bus.in_byte;
                valid_d = 1'b1;
                sof_d   = at_origin;
                eol_d   = eol;
                done_d  = last;
                step    = 1'b1;
                state_d = last ? S_IDLE : S_R;
            end
        end
    end

    // state, partial-pixel and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            g_q     <= '0;
            red_q   <= '0;
            grn_q   <= '0;
            blu_q   <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            g_q     <= g_d;
            red_q   <= red_d;
            grn_q   <= grn_d;
            blu_q   <= blu_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_red_pixel   = red_q;
    assign bus.out_green_pixel = grn_q;
    assign bus.out_blue_pixel  = blu_q;
    assign bus.RGB_valid_out   = valid_q;
    assign bus.sof_out         = sof_q;
    assign bus.eol_out         = eol_q;
    assign bus.frame_done      = done_q;
    assign bus.frame_err       = err_q;

endmodule

// File: tb/tb_rgb_byte_assembler.sv
// tb_rgb_byte_assembler: directed checks of pixel assembly, flags, errors, reset and enable
module tb_rgb_byte_assembler;
    import rgb_byte_assembler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] hr = 8'h00, hg = 8'h00, hb = 8'h00;

    rgb_byte_assembler_if bus();

    rgb_byte_assembler #(.IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .RGB_enable(en),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic push(input logic v, input logic s, input logic [7:0] b);
        @(negedge clk);
        bus.byte_valid_in = v;
        bus.sof_in        = s;
        bus.in_byte       = b;
        @(posedge clk);
        #1;
    endtask

    // flags = {valid, sof, eol, done, err}; pixel expected is hr/hg/hb
    task automatic chk(input string tag, input logic [4:0] flags);
        logic [28:0] obs, exp;
        obs = {bus.RGB_valid_out, bus.sof_out, bus.eol_out, bus.frame_done, bus.frame_err,
               bus.out_red_pixel, bus.out_green_pixel, bus.out_blue_pixel};
        exp = {flags, hr, hg, hb};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pix(input string tag, input logic [7:0] r, g, b, input logic [4:0] flags);
        hr = r;
        hg = g;
        hb = b;
        chk(tag, flags);
    endtask

    initial begin
        bus.byte_valid_in = 1'b0;
        bus.sof_in        = 1'b0;
        bus.in_byte       = 8'h00;
        push(0, 0, 8'h00);
        push(0, 0, 8'h00);
        chk("reset", 5'b00000);
        rst = 1'b0;
        en  = 1'b1;
        push(0, 0, 8'h00);
        chk("idle_after_reset", 5'b00000);

        // full 4x2 frame of back-to-back bytes
        for (int i = 1; i <= 24; i++) begin
            push(1, i == 1, 8'(i));
            if (i % 3 == 0)
                pix($sformatf("frame_px%0d", i / 3), 8'(i - 2), 8'(i - 1), 8'(i),
                    {1'b1, i == 3, (i % 12) == 0, i == 24, 1'b0});
            else
                chk($sformatf("frame_byte%0d", i), 5'b00000);
        end
        checks++;
        assert (dut.state_q === S_IDLE) else begin
            errors++;
            $error("FAIL fsm_idle observed=%0d expected=%0d", dut.state_q, S_IDLE);
        end

        // bytes without sof in idle are dropped silently
        for (int i = 0; i < 3; i++) begin
            push(1, 0, 8'h99);
            chk("idle_discard", 5'b00000);
        end

        // gapped bytes, with an unqualified sof inside a gap
        push(1, 1, 8'hAA);
        chk("gap_aa", 5'b00000);
        push(1, 0, 8'hBB);
        chk("gap_bb", 5'b00000);
        push(0, 1, 8'h55);
        chk("gap_sof_novalid", 5'b00000);
        push(0, 0, 8'h00);
        push(0, 0, 8'h00);
        chk("gap_hold", 5'b00000);
        push(1, 0, 8'hCC);
        pix("gap_pixel", 8'hAA, 8'hBB, 8'hCC, 5'b11000);
        push(0, 0, 8'h00);
        chk("gap_one_cycle", 5'b00000);

        // sof arriving while blue is expected
        push(1, 0, 8'h10);
        push(1, 0, 8'h20);
        chk("err_pre", 5'b00000);
        push(1, 1, 8'h30);
        chk("err_pulse", 5'b00001);
        push(1, 0, 8'h40);
        chk("err_one_cycle", 5'b00000);
        push(1, 0, 8'h50);
        pix("err_new_frame", 8'h30, 8'h40, 8'h50, 5'b11000);

        // reset in the middle of a pixel
        push(1, 0, 8'h61);
        push(1, 0, 8'h62);
        @(negedge clk);
        rst = 1'b1;
        bus.byte_valid_in = 1'b0;
        @(posedge clk);
        #1;
        pix("mid_reset", 8'h00, 8'h00, 8'h00, 5'b00000);
        rst = 1'b0;
        push(1, 1, 8'h71);
        push(1, 0, 8'h72);
        push(1, 0, 8'h73);
        pix("post_reset_px0", 8'h71, 8'h72, 8'h73, 5'b11000);
        push(1, 0, 8'h74);
        push(1, 0, 8'h75);
        push(1, 0, 8'h76);
        pix("post_reset_px1", 8'h74, 8'h75, 8'h76, 5'b10000);

        // enable dropped with the blue byte on the bus
        push(1, 0, 8'h81);
        push(1, 0, 8'h82);
        en = 1'b0;
        push(1, 0, 8'h83);
        chk("enable_drop_blue", 5'b00000);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(1, 0, 8'(8'h84 + i));
            chk("enable_wait_sof", 5'b00000);
        end
        push(1, 1, 8'h91);
        push(1, 0, 8'h92);
        push(1, 0, 8'h93);
        pix("enable_px0", 8'h91, 8'h92, 8'h93, 5'b11000);
        for (int p = 1; p < 4; p++) begin
            push(1, 0, 8'(8'h91 + 3 * p));
            push(1, 0, 8'(8'h92 + 3 * p));
            push(1, 0, 8'(8'h93 + 3 * p));
            pix($sformatf("enable_px%0d", p), 8'(8'h91 + 3 * p), 8'(8'h92 + 3 * p),
                8'(8'h93 + 3 * p), {1'b1, 1'b0, p == 3, 1'b0, 1'b0});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb_byte_assembler.md
RGB_BYTE_ASSEMBLER -- requirements
Module: rgb_byte_assembler

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 640, meaning pixels per line.
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 480, meaning lines per frame.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 The block SHALL have port RGB_enable  input  1  block enable, driven by the controller.
REQ-006 The block SHALL have port in_byte  input  8  serial byte stream from the camera, ordered R,G,B per pixel.
REQ-007 The block SHALL have port byte_valid_in  input  1  in_byte is valid this cycle.
REQ-008 The block SHALL have port sof_in  input  1  start of frame; qualified by byte_valid_in; marks the first red byte.
REQ-009 The block SHALL have port out_red_pixel  output  8  assembled red component.
REQ-010 The block SHALL have port out_green_pixel  output  8  assembled green component.
REQ-011 The block SHALL have port out_blue_pixel  output  8  assembled blue component.
REQ-012 The block SHALL have port RGB_valid_out  output  1  one-cycle pulse; the pixel outputs are valid.
REQ-013 The block SHALL have port sof_out  output  1  asserted with RGB_valid_out for pixel (0,0).
REQ-014 The block SHALL have port eol_out  output  1  asserted with RGB_valid_out for the last pixel of each line.
REQ-015 The block SHALL have port frame_done  output  1  asserted with RGB_valid_out for the last pixel of the frame.
REQ-016 The block SHALL have port frame_err  output  1  one-cycle pulse on a protocol error.

Function
REQ-017 The FSM SHALL have four states:
  - S_IDLE: wait for sof.
  - S_R: expect red.
  - S_G: expect green.
  - S_B: expect blue.
REQ-018 In S_IDLE, a byte with sof_in=1 SHALL be latched as red, clear col/row to 0, and move to S_G.
REQ-019 In S_IDLE, bytes with sof_in=0 SHALL be discarded without error.
REQ-020 Each accepted byte SHALL advance the FSM S_R→S_G→S_B; cycles with byte_valid_in=0 SHALL hold state and latched data.
REQ-021 On an accepted blue byte, the outputs SHALL update on the next clock edge:
  - all three components update together;
  - RGB_valid_out=1 for exactly that one cycle (latency 1 clock after the blue byte).
REQ-022 Pixel outputs SHALL hold their last value when RGB_valid_out=0.
REQ-023 col SHALL increment per emitted pixel and wrap to 0 at IMG_WIDTH-1; on wrap, row SHALL increment.
REQ-024 eol_out SHALL be 1 when col=IMG_WIDTH-1.
REQ-025 At col=IMG_WIDTH-1 and row=IMG_HEIGHT-1:
  - frame_done SHALL pulse;
  - the FSM SHALL go to S_IDLE.
  Otherwise the FSM SHALL go to S_R after the blue byte.
REQ-026 On sof_in=1 with an accepted byte in S_G, S_B, or S_R with (col,row)≠(0,0):
  - frame_err SHALL pulse the next cycle;
  - the partial pixel SHALL be discarded;
  - the byte SHALL be taken as red of a new frame (col=row=0, state S_G).
REQ-027 sof_in=1 without byte_valid_in SHALL be ignored.
REQ-028 RGB_enable=0 SHALL force S_IDLE and discard any partial pixel and counters.
  - Outputs hold their values; valid and flag outputs are 0.
  - The cycle of deassertion emits nothing.
REQ-029 A blue byte accepted in the same cycle RGB_enable falls SHALL be dropped.
REQ-030 Back-to-back bytes every cycle SHALL be sustained: one pixel per 3 clocks, no stall; the block has no backpressure.

Reset
REQ-031 With rst=1 at a clock edge:
  - state→S_IDLE;
  - col, row, and the latched R/G → 0;
  - all pixel outputs → 0;
  - RGB_valid_out, sof_out, eol_out, frame_done, frame_err → 0.
REQ-032 rst SHALL take priority over all other inputs, including mid-pixel and mid-frame.

Structure
REQ-033 The shared package SHALL hold:
  - FSM state encoding (2-bit localparams S_IDLE/S_R/S_G/S_B);
  - PIXEL_W=8;
  - the counter-width function (clog2).
REQ-034 col/row tracking SHALL be a sub-module, pixel_position_counter, parameterised by IMG_WIDTH/IMG_HEIGHT.
  - Inputs: step, clear.
  - Outputs: col, row, eol, last.
REQ-035 The output stage SHALL be directly compatible with the downstream RGB arithmetic stage's in_*_pixel/RGB_valid_in ports.

Verification
REQ-036 IMG_WIDTH=4, IMG_HEIGHT=2; sof on first byte, then 24 consecutive bytes 0x01..0x18 → 8 pixels:
  - first pixel (01,02,03) with sof_out;
  - eol_out on pixels 4 and 8;
  - frame_done on pixel 8 (16,17,18);
  - FSM ends in S_IDLE.
REQ-037 Bytes AA,BB,CC with byte_valid_in gaps of 0–3 cycles → single pixel (AA,BB,CC), RGB_valid_out 1 cycle after the CC byte.
REQ-038 sof during S_B after R=10, G=20 → frame_err pulse; next G=0x40, B=0x50 → pixel (sof byte,40,50) with sof_out.
REQ-039 Bytes without sof in S_IDLE → no RGB_valid_out and no frame_err.
REQ-040 rst=1 after R,G accepted → all outputs 0; the next sof frame assembles correctly from (0,0).
REQ-041 RGB_enable dropped mid-line for 1 cycle, then re-raised → no pixel emitted until a new sof; counters restart at 0.
